// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch handshake: request/address out, ready/data back.
// master = fetch_sequencer, slave = instruction memory.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// IF-stage controller: owns the PC, sequences imem fetches, loads IF/ID.
// Ports: clock/reset_n, imem (master), branch/stall in, pc + IF/ID out.
module fetch_sequencer #(
  parameter int              ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int              PC_STEP     = 4,
  parameter int              BOOT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  fetch_sequencer_if.master imem,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic              if_id_valid,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    REDIRECT,
    HOLD
  } state_t;

  localparam logic [3:0] BOOT_LAST =
    4'(BOOT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(PC_STEP);

  state_t            state_q;
  logic [3:0]        boot_cnt_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] redir_q;
  logic [ADDR_W-1:0] hold_q;
  logic [ADDR_W-1:0] instr_q;
  logic [ADDR_W-1:0] pc4_q;
  logic              valid_q;
  logic              req_q;
  logic [15:0]       cnt_q;

  logic              acc;
  logic [ADDR_W-1:0] pc_inc;

  assign acc    = req_q & imem.imem_ready;
  assign pc_inc = pc_q + STEP;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      pc_q       <= RESET_PC;
      redir_q    <= '0;
      hold_q     <= '0;
      instr_q    <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        BOOT: begin
          boot_cnt_q <= boot_cnt_q + 4'd1;
          if (branch_taken) begin
            pc_q <= branch_target;
          end
          if (boot_cnt_q == BOOT_LAST) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        FETCH: begin
          if (branch_taken && acc) begin
            pc_q    <= branch_target;
            valid_q <= 1'b0;
          end else if (branch_taken) begin
            // word still in flight: finish it
            redir_q <= branch_target;
            valid_q <= 1'b0;
            state_q <= REDIRECT;
          end else if (acc && !stall) begin
            instr_q <= imem.imem_rdata;
            pc4_q   <= pc_inc;
            valid_q <= 1'b1;
            pc_q    <= pc_inc;
            cnt_q   <= cnt_q + 16'd1;
          end else if (acc) begin
            hold_q  <= imem.imem_rdata;
            pc_q    <= pc_inc;
            state_q <= HOLD;
            req_q   <= 1'b0;
          end else if (!stall) begin
            valid_q <= 1'b0;
          end
        end
        REDIRECT: begin
          valid_q <= 1'b0;
          if (acc) begin
            pc_q    <= branch_taken ?
                       branch_target : redir_q;
            state_q <= FETCH;
          end else if (branch_taken) begin
            redir_q <= branch_target;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            pc_q    <= branch_target;
            valid_q <= 1'b0;
            state_q <= FETCH;
            req_q   <= 1'b1;
          end else if (!stall) begin
            // pc already points past the held word
            instr_q <= hold_q;
            pc4_q   <= pc_q;
            valid_q <= 1'b1;
            cnt_q   <= cnt_q + 16'd1;
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc4      = pc4_q;
  assign if_id_valid    = valid_q;
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with IF/ID scoreboard.
// Memory returns addr + 16'h1000 for every fetch address.
module tb_fetch_sequencer;

  logic        clock;
  logic        reset_n;
  logic        ready;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        stall;
  logic [15:0] pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc4;
  logic        if_id_valid;
  logic [15:0] fetch_count;

  int vectors = 0;
  int fails   = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc4;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] prev_cnt = '0;

  fetch_sequencer_if #(.ADDR_W(16)) imem_if();

  assign imem_if.imem_ready = ready;
  assign imem_if.imem_rdata =
    imem_if.imem_addr + 16'h1000;

  fetch_sequencer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .imem          (imem_if),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .fetch_count   (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(string nm,
                     logic [15:0] act,
                     logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(logic [15:0] i,
                      logic [15:0] p4);
    exp_t e;
    e.instr = i;
    e.pc4   = p4;
    sb.push_back(e);
  endtask

  // Monitor: every IF/ID delivery bumps fetch_count.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (fetch_count == prev_cnt + 16'd1) begin
      if (sb.size() == 0) begin
        vectors++;
        fails++;
        $display("FAIL sb_extra: got %h want none",
                 if_id_instr);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", if_id_instr, e.instr);
        chk("sb_pc4", if_id_pc4, e.pc4);
        chk("sb_valid", 16'(if_id_valid), 16'd1);
      end
    end else if (fetch_count != prev_cnt &&
                 fetch_count != 16'd0) begin
      vectors++;
      fails++;
      $display("FAIL cnt_jump: got %h want %h",
               fetch_count, prev_cnt + 16'd1);
    end
    prev_cnt = fetch_count;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want done");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    ready         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    stall         = 1'b0;
    #12;
    chk("rst_req", 16'(imem_if.imem_req), 16'd0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_valid", 16'(if_id_valid), 16'd0);
    chk("rst_cnt", fetch_count, 16'd0);
    chk("rst_instr", if_id_instr, 16'd0);
    chk("rst_pc4", if_id_pc4, 16'd0);

    // boot: two idle cycles, ready ignored
    step();
    reset_n = 1'b1;
    ready   = 1'b1;
    step();
    chk("boot1_req", 16'(imem_if.imem_req), 16'd0);
    chk("boot1_cnt", fetch_count, 16'd0);
    step();
    chk("boot2_req", 16'(imem_if.imem_req), 16'd1);
    chk("boot2_addr", imem_if.imem_addr, 16'h0000);

    // back-to-back fetch
    push(16'h1000, 16'h0004);
    push(16'h1004, 16'h0008);
    push(16'h1008, 16'h000C);
    step();
    step();
    step();
    chk("b2b_cnt", fetch_count, 16'd3);
    chk("b2b_pc", pc, 16'h000C);

    // ready every third cycle: 0x0C, 0x10
    ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      logic [15:0] a;
      a = 16'h000C + 16'(4 * k);
      step();
      chk("wait_valid", 16'(if_id_valid), 16'd0);
      chk("wait_addr1", imem_if.imem_addr, a);
      step();
      chk("wait_addr2", imem_if.imem_addr, a);
      chk("wait_req", 16'(imem_if.imem_req), 16'd1);
      ready = 1'b1;
      push(a + 16'h1000, a + 16'd4);
      step();
      chk("acc_valid", 16'(if_id_valid), 16'd1);
      chk("acc_pc", pc, a + 16'd4);
      ready = 1'b0;
    end

    // stall on acceptance at 0x14, 4 cycles
    ready = 1'b1;
    stall = 1'b1;
    step();
    chk("hold_req", 16'(imem_if.imem_req), 16'd0);
    chk("hold_pc", pc, 16'h0018);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_instr", if_id_instr, 16'h1010);
      chk("hold_pc4", if_id_pc4, 16'h0014);
      chk("hold_pcs", pc, 16'h0018);
    end
    ready = 1'b0;
    stall = 1'b0;
    push(16'h1014, 16'h0018);
    step();
    chk("rel_cnt", fetch_count, 16'd6);
    chk("rel_req", 16'(imem_if.imem_req), 16'd1);
    chk("rel_addr", imem_if.imem_addr, 16'h0018);

    // redirect while 0x18 waits, second wins
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    step();
    branch_taken = 1'b0;
    chk("rd_valid", 16'(if_id_valid), 16'd0);
    chk("rd_addr", imem_if.imem_addr, 16'h0018);
    step();
    chk("rd_addr2", imem_if.imem_addr, 16'h0018);
    branch_taken  = 1'b1;
    branch_target = 16'h0080;
    step();
    branch_taken = 1'b0;
    ready        = 1'b1;
    step();
    chk("rd_pc", pc, 16'h0080);
    chk("rd_cnt", fetch_count, 16'd6);
    chk("rd_valid2", 16'(if_id_valid), 16'd0);
    ready = 1'b0;
    step();
    chk("rd_addr3", imem_if.imem_addr, 16'h0080);
    ready = 1'b1;
    push(16'h1080, 16'h0084);
    step();
    chk("rd_pc2", pc, 16'h0084);

    // branch coincident with acceptance
    branch_taken  = 1'b1;
    branch_target = 16'h0100;
    step();
    chk("bacc_pc", pc, 16'h0100);
    chk("bacc_valid", 16'(if_id_valid), 16'd0);
    chk("bacc_cnt", fetch_count, 16'd7);
    ready         = 1'b0;
    branch_target = 16'h0200;
    step();
    branch_target = 16'h0300;
    ready         = 1'b1;
    step();
    branch_taken = 1'b0;
    chk("rdacc_pc", pc, 16'h0300);

    // branch beats stall in HOLD
    push(16'h1300, 16'h0304);
    step();
    stall = 1'b1;
    step();
    chk("hb_req", 16'(imem_if.imem_req), 16'd0);
    chk("hb_pc", pc, 16'h0308);
    branch_taken  = 1'b1;
    branch_target = 16'hFFFC;
    step();
    chk("hb_pc2", pc, 16'hFFFC);
    chk("hb_valid", 16'(if_id_valid), 16'd0);
    chk("hb_cnt", fetch_count, 16'd8);
    chk("hb_req2", 16'(imem_if.imem_req), 16'd1);
    branch_taken = 1'b0;
    stall        = 1'b0;
    push(16'h0FFC, 16'h0000);
    step();
    chk("wrap_pc", pc, 16'h0000);
    push(16'h1000, 16'h0004);
    step();
    chk("wrap_pc2", pc, 16'h0004);
    ready = 1'b0;
    step();

    // async reset mid-wait
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_req", 16'(imem_if.imem_req), 16'd0);
    chk("ar_pc", pc, 16'h0000);
    chk("ar_cnt", fetch_count, 16'd0);
    chk("ar_instr", if_id_instr, 16'd0);
    chk("ar_pc4", if_id_pc4, 16'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("ar_boot1", 16'(imem_if.imem_req), 16'd0);
    step();
    chk("ar_boot2", 16'(imem_if.imem_req), 16'd1);
    ready = 1'b1;
    push(16'h1000, 16'h0004);
    step();
    chk("ar_cnt2", fetch_count, 16'd1);
    ready = 1'b0;
    step();
    step();
    chk("sb_empty", 16'(sb.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the instruction-fetch stage of the 16-bit processor.
- Owns the PC register and drives the request/ready handshake to instruction memory.
- Loads the IF/ID pipeline register, and handles stalls from hazard detection and redirects from taken branches (PCSrc).
- Replaces the free-running PC/mux update with a sequenced controller that tolerates multi-cycle memory.

Parameters:
ADDR_W, 16, PC and instruction width.
RESET_PC, 16'h0000, PC value loaded at reset.
PC_STEP, 4, PC increment per accepted instruction.
BOOT_CYCLES, 2, idle cycles after reset release before the first request (1..15).

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  ADDR_W  fetch address, equal to pc.
imem_ready  in  1  memory returns data this cycle.
imem_rdata  in  ADDR_W  instruction word, valid when imem_ready.
branch_taken  in  1  PCSrc, one-cycle redirect pulse.
branch_target  in  ADDR_W  redirect address, sampled with branch_taken.
stall  in  1  ID hazard stall, level.
pc  out  ADDR_W  current fetch PC.
if_id_instr  out  ADDR_W  IF/ID instruction register.
if_id_pc4  out  ADDR_W  IF/ID PC+PC_STEP register.
if_id_valid  out  1  IF/ID contents valid.
fetch_count  out  16  instructions delivered to IF/ID, wraps at 16'hFFFF to 0.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=BOOT, boot counter=0, pc=RESET_PC.
  - imem_req=0, if_id_instr=0, if_id_pc4=0, if_id_valid=0, fetch_count=0.
  - Hold register cleared, redirect flag cleared.
  - Reset mid-request aborts the request immediately, with no further handshake.
- Acceptance: an instruction is accepted when imem_req=1 and imem_ready=1. imem_ready while imem_req=0 is ignored.
- imem_addr=pc at all times. pc changes only on the cycle of an acceptance, or in BOOT/HOLD. Address is stable while imem_req=1 and not yet accepted.
- BOOT:
  - imem_req=0; counter increments each cycle.
  - After BOOT_CYCLES cycles, go to FETCH.
  - A branch_taken in BOOT loads pc=branch_target.
- FETCH: imem_req=1. Each cycle, in priority order:
  1. branch_taken=1 and acceptance: discard the word, pc<=branch_target, if_id_valid<=0, stay in FETCH.
  2. branch_taken=1, no acceptance: latch the target into the redirect register, if_id_valid<=0, go to REDIRECT.
  3. Acceptance with stall=0: if_id_instr<=imem_rdata, if_id_pc4<=pc+PC_STEP, if_id_valid<=1, pc<=pc+PC_STEP, fetch_count+1.
  4. Acceptance with stall=1: word into hold register, pc<=pc+PC_STEP, IF/ID unchanged, go to HOLD.
  5. No acceptance, stall=0: if_id_valid<=0 (bubble).
  6. No acceptance, stall=1: IF/ID unchanged.
- REDIRECT:
  - imem_req=1 at the old address until accepted. The returned word is discarded and never reaches IF/ID.
  - On acceptance: pc<=redirect target, go to FETCH.
  - A further branch_taken in REDIRECT overwrites the target (latest wins). If it coincides with acceptance, its target is used.
  - if_id_valid=0 throughout.
- HOLD:
  - imem_req=0.
  - When stall=0: IF/ID<=hold word, if_id_pc4<=pc (already advanced), if_id_valid<=1, fetch_count+1, go to FETCH.
  - branch_taken in HOLD: drop the hold word, pc<=branch_target, if_id_valid<=0, go to FETCH. Branch beats stall release.
- Arithmetic: PC addition is modulo 2^16. 16'hFFFC+4 wraps to 16'h0000 with no error.
- Registers update only on the rising clock edge, except on reset.

Test Plan:
- Reset release, imem_ready tied 1, RESET_PC=0 -> imem_req rises after 2 cycles. IF/ID then receives addresses 0,4,8 on consecutive cycles, if_id_pc4=4,8,12, fetch_count=3.
- imem_ready asserted every 3rd cycle -> imem_addr held stable across wait cycles, if_id_valid pulses once per acceptance with bubbles between.
- stall=1 for 4 cycles during an acceptance at pc=8 -> imem_req=0, IF/ID frozen. On release, if_id_instr=mem[8], if_id_pc4=12, then fetching resumes at 12.
- branch_taken with target 16'h0040 while request at 16'h0010 is waiting -> the 0x0010 word is discarded, next request at 0x0040, if_id_valid=0 until it returns. A second branch to 16'h0080 before the ready -> fetch goes to 0x0080.
- branch_taken and stall both high in HOLD -> hold word dropped, pc=target, if_id_valid=0. pc=16'hFFFC accepted -> pc=16'h0000.
- reset_n pulsed low mid-wait -> all outputs reset asynchronously, BOOT sequence restarts.
